// File: rtl/fetch_unit.sv
// Instruction fetch unit: assembles INSTR_BITS-wide instructions from consecutive memory words.
// Define FETCH_UNIT_PREFETCH_EN to add a one-entry prefetch buffer behind ir.
module fetch_unit #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned MEM_DATA_BITS = 8,
  parameter int unsigned INSTR_BITS    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_BITS-1:0]     mem_address,
  output logic                     mem_read_en,
  input  logic                     mem_ack,
  input  logic [MEM_DATA_BITS-1:0] mem_rdata,
  output logic [INSTR_BITS-1:0]    ir,
  output logic [ADDR_BITS-1:0]     ir_pc,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  input  logic                     jump_en,
  input  logic [ADDR_BITS-1:0]     jump_target
);

  localparam int unsigned Words = INSTR_BITS / MEM_DATA_BITS;
  localparam int unsigned KW    = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [KW-1:0] KLast = KW'(Words - 1);

  if (INSTR_BITS == 0 || (INSTR_BITS % MEM_DATA_BITS) != 0) begin : g_bad_cfg
    $error("INSTR_BITS must be a non-zero multiple of MEM_DATA_BITS");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ip_q, ip_d;
  logic [KW-1:0]          k_q, k_d;
  logic [INSTR_BITS-1:0]  asm_q, asm_d;
  logic [ADDR_BITS-1:0]   pc0_q, pc0_d;
  logic [INSTR_BITS-1:0]  ir_q, ir_d;
  logic [ADDR_BITS-1:0]   ir_pc_q, ir_pc_d;
  logic                   ir_valid_q, ir_valid_d;
  logic [INSTR_BITS-1:0]  buf_q, buf_d;
  logic [ADDR_BITS-1:0]   buf_pc_q, buf_pc_d;
  logic                   buf_valid_q, buf_valid_d;

  logic                   xfer, ack, done;
  logic [INSTR_BITS-1:0]  word_asm;
  logic [ADDR_BITS-1:0]   done_pc;

  assign mem_address = ip_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;

`ifdef FETCH_UNIT_PREFETCH_EN
  // Keep fetching until both ir and the buffer hold an instruction.
  assign mem_read_en = (state_q == StFetch) && !(ir_valid_q && buf_valid_q);
`else
  assign mem_read_en = (state_q == StFetch);
`endif

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    k_d         = k_q;
    asm_d       = asm_q;
    pc0_d       = pc0_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    buf_d       = buf_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;

    xfer = ir_valid_q && ir_ready;
    // A same-cycle jump drops the acked word entirely.
    ack  = mem_read_en && mem_ack && !jump_en;
    done = ack && (k_q == KLast);

    word_asm = asm_q;
    for (int unsigned i = 0; i < Words; i++) begin
      if (k_q == KW'(i)) begin
        word_asm[INSTR_BITS-1-i*MEM_DATA_BITS -: MEM_DATA_BITS] = mem_rdata;
      end
    end
    done_pc = (k_q == '0) ? ip_q : pc0_q;

    if (ack) begin
      asm_d = word_asm;
      ip_d  = ip_q + ADDR_BITS'(1);
      k_d   = done ? '0 : k_q + KW'(1);
      if (k_q == '0) pc0_d = ip_q;
    end

`ifdef FETCH_UNIT_PREFETCH_EN
    if (state_q == StIdle) state_d = StFetch;
    if (xfer) begin
      if (buf_valid_q) begin
        ir_d        = buf_q;
        ir_pc_d     = buf_pc_q;
        buf_valid_d = 1'b0;
      end else begin
        ir_valid_d  = 1'b0;
      end
    end
    if (done) begin
      if (!ir_valid_q || (xfer && !buf_valid_q)) begin
        ir_d        = word_asm;
        ir_pc_d     = done_pc;
        ir_valid_d  = 1'b1;
      end else begin
        buf_d       = word_asm;
        buf_pc_d    = done_pc;
        buf_valid_d = 1'b1;
      end
    end
`else
    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (done) begin
          ir_d       = word_asm;
          ir_pc_d    = done_pc;
          ir_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (xfer) begin
          ir_valid_d = 1'b0;
          state_d    = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
`endif

    if (jump_en) begin
      ip_d        = jump_target;
      k_d         = '0;
      ir_valid_d  = 1'b0;
      buf_valid_d = 1'b0;
      state_d     = StFetch;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      ip_q        <= '0;
      k_q         <= '0;
      asm_q       <= '0;
      pc0_q       <= '0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      buf_q       <= '0;
      buf_pc_q    <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      k_q         <= k_d;
      asm_q       <= asm_d;
      pc0_q       <= pc0_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      buf_q       <= buf_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus randomized jump/latency/backpressure runs,
// with transfers checked by a scoreboard fed from a memory-image instruction model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  mem_address;
  logic        mem_read_en;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        jump_en;
  logic [7:0]  jump_target;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_BITS    (8),
    .MEM_DATA_BITS(8),
    .INSTR_BITS   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_address(mem_address),
    .mem_read_en(mem_read_en),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .jump_en    (jump_en),
    .jump_target(jump_target)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] ir;
  } exp_t;

  exp_t       exp_q[$];
  int         rel_q[$];
  logic [7:0] mem [256];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int xfer_cnt = 0;
  int lat_fixed = 0;
  bit lat_rand = 1'b0;
`ifdef FETCH_UNIT_PREFETCH_EN
  localparam bit Pf = 1'b1;
`else
  localparam bit Pf = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected instruction stream: consecutive address pairs from the memory image.
  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc, ir: {mem[pc], mem[pc + 8'd1]}});
      pc = pc + 8'd2;
    end
  endtask

  // Memory: acks after cur_lat waiting cycles; a withdrawn/changed request restarts the wait.
  initial begin : memory
    int wait_cnt = 0;
    int cur_lat = 0;
    logic [7:0] prev_addr = 8'h0;
    bit prev_ack = 1'b0;
    bit have_prev = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 8'h0;
    forever begin
      tick();
      if (reset && mem_read_en) begin
        if (have_prev && mem_address == prev_addr && !prev_ack) wait_cnt++;
        else begin
          wait_cnt = 0;
          cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
        end
        mem_ack = (wait_cnt >= cur_lat);
      end else begin
        mem_ack = 1'b0;
      end
      have_prev = reset && mem_read_en;
      prev_addr = mem_address;
      prev_ack  = mem_ack;
      mem_rdata = mem_ack ? mem[mem_address] : 8'($urandom);
    end
  end

  // Monitor: a transfer happens at the next posedge when valid && ready at the negedge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && ir_valid && ir_ready) begin
        xfer_cnt++;
        rel_q.push_back(cyc + 1 - t0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: got ir=0x%0h pc=0x%0h, expected no transfer", ir, ir_pc);
        end else begin
          e = exp_q.pop_front();
          check("xfer_ir_pc", {8'h0, ir_pc, ir}, {8'h0, e.pc, e.ir});
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    ir_ready = 1'b0;
    jump_en = 1'b0;
    tick();
    tick();
    check("rst_ir", ir, 0);
    check("rst_ir_pc", ir_pc, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_read_en", mem_read_en, 0);
    check("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    rel_q.delete();
    reset = 1'b1;
    tick();
    t0 = cyc;
    check("start_read_en", mem_read_en, 1);
    check("start_address", mem_address, 0);
  endtask

  task automatic take(input int n, input bit rnd);
    int start = xfer_cnt;
    int g = 0;
    while (xfer_cnt - start < n && g < 400) begin
      ir_ready = rnd ? 1'($urandom) : 1'b1;
      tick();
      g++;
    end
    ir_ready = 1'b0;
    check("take_count", xfer_cnt - start, n);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ir_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin : stim
    int n, en_cnt, unstable;
    logic [7:0] tgt;
    ir_ready = 1'b0;
    jump_en = 1'b0;
    jump_target = 8'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;

    // Back-to-back delivery and spacing.
    do_reset();
    push_seq(8'h00, 2);
    take(2, 1'b0);
    check("first_xfer_cycle", rel_q[0], 3);
    check("second_xfer_cycle", rel_q[1], Pf ? 5 : 6);

    // Backpressure: ir stable; prefetch fetches exactly one more instruction.
    do_reset();
    push_seq(8'h00, 2);
    wait_valid(n);
    check("valid_latency", n, 2);
    en_cnt = 0;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_read_en) en_cnt++;
      if (!ir_valid || ir != 16'h1234 || ir_pc != 8'h00) unstable++;
      tick();
    end
    check("hold_read_en_cycles", en_cnt, Pf ? 2 : 0);
    check("hold_ir_unstable", unstable, 0);
    check("hold_read_en_end", mem_read_en, 0);
    check("hold_address_end", mem_address, Pf ? 4 : 2);
    take(2, 1'b0);

    // Slow memory: three wait cycles per word.
    lat_fixed = 3;
    do_reset();
    push_seq(8'h00, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) check("slow_addr_word0", mem_address, 0);
      if (i == 7) check("slow_addr_word1", mem_address, 1);
      if (i == 7) check("slow_not_yet_valid", ir_valid, 0);
    end
    check("slow_valid_at_8", ir_valid, 1);
    take(1, 1'b0);
    lat_fixed = 0;

    // Jump after the first byte is acked, coinciding with the second ack.
    do_reset();
    push_seq(8'h02, 1);
    tick();
    jump_en = 1'b1;
    jump_target = 8'h02;
    tick();
    jump_en = 1'b0;
    check("jump_addr", mem_address, 2);
    check("jump_read_en", mem_read_en, 1);
    wait_valid(n);
    check("jump_valid_latency", n, 2);
    take(1, 1'b0);

    // Instruction straddling the address wrap.
    mem[255] = 8'hAB;
    mem[0] = 8'hCD;
    do_reset();
    push_seq(8'hFF, 1);
    jump_en = 1'b1;
    jump_target = 8'hFF;
    tick();
    jump_en = 1'b0;
    wait_valid(n);
    check("wrap_valid_latency", n, 2);
    check("wrap_next_addr", mem_address, 1);
    take(1, 1'b0);

    // Reset while an instruction is held, then fetching restarts at 0.
    do_reset();
    wait_valid(n);
    do_reset();
    push_seq(8'h00, 1);
    take(1, 1'b0);

    // Randomized jumps, latency and backpressure.
    lat_rand = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int s = 0; s < 40; s++) begin
      n = int'($urandom_range(1, 5));
      tgt = 8'($urandom);
      jump_en = 1'b1;
      jump_target = tgt;
      tick();
      jump_en = 1'b0;
      push_seq(tgt, n);
      take(n, 1'b1);
    end
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit: assembles INSTR_BITS-wide instructions from consecutive MEM_DATA_BITS-wide memory words and presents them to the decoder over a valid/ready handshake. It sits between the instruction memory and the execution core. Fetch address advances one word per memory read. The unit supports variable memory latency, jump redirects that flush partial fetches, and an optional prefetch buffer.

## Interface
- ADDR_BITS, 8, memory address width; also the width of the instruction pointer.
- MEM_DATA_BITS, 8, memory word width.
- INSTR_BITS, 16, instruction width. It must be a non-zero multiple of MEM_DATA_BITS; any other value is an elaboration error. WORDS = INSTR_BITS/MEM_DATA_BITS.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low; sampled on posedge clk.
- mem_address  out  ADDR_BITS  read address.
- mem_read_en  out  1  read request; level-held until acknowledged or withdrawn.
- mem_ack  in  1  memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata  in  MEM_DATA_BITS  read data.
- ir  out  INSTR_BITS  assembled instruction.
- ir_pc  out  ADDR_BITS  address of the first word of ir.
- ir_valid  out  1  ir/ir_pc hold a valid instruction.
- ir_ready  in  1  consumer accepts ir this cycle.
- jump_en  in  1  redirect request.
- jump_target  in  ADDR_BITS  new fetch address.

## Operation
- Reset (reset==0 at posedge) sets the following to 0: ip, word counter, ir, ir_pc, ir_valid, mem_address, mem_read_en. The prefetch buffer is also emptied.
- States:
  - FETCH: mem_read_en=1, mem_address=ip. On mem_ack:
    - write mem_rdata into slice k of the assembly register;
    - ip <= ip+1 (wraps mod 2^ADDR_BITS);
    - k <= k+1.
    - Word k=0 lands in bits [INSTR_BITS-1 -: MEM_DATA_BITS] (big-endian).
    - On the ack with k==WORDS-1:
      - load ir and ir_pc (ir_pc = address captured at k==0);
      - set ir_valid=1;
      - set k=0 and go to HOLD.
  - HOLD: mem_read_en=0. On ir_valid && ir_ready, clear ir_valid and go to FETCH.
- Handshake: a transfer occurs on any posedge with ir_valid && ir_ready. ir and ir_pc are stable while ir_valid=1 and no transfer occurs.
- Jump (jump_en=1 at posedge), in any state:
  - ip <= jump_target; k <= 0; ir_valid <= 0; prefetch buffer emptied;
  - any partially assembled instruction is discarded;
  - state <= FETCH.
- Jump priorities and side effects:
  - Jump takes priority over a same-cycle mem_ack; that word is dropped and does not advance ip.
  - A same-cycle ir_valid && ir_ready transfer still counts as consumed.
  - An outstanding request is withdrawn: mem_address changes to jump_target on the next cycle while mem_read_en stays 1. Memory must tolerate a withdrawn request.
- WORDS==1: every ack completes an instruction.
- ip wrap: an instruction whose words straddle address 2^ADDR_BITS-1 → 0 is fetched normally; ir_pc holds the pre-wrap address.

## Timing
- The first request is issued in the first cycle after reset deasserts, with mem_read_en=1 and mem_address=0.
- Memory latency is variable: each word takes ≥1 cycle, set by mem_ack.
- With single-cycle ack:
  - ir_valid rises WORDS cycles after entering FETCH.
  - Sustained throughput without prefetch is one instruction per WORDS+1 cycles, because HOLD lasts at least one cycle.
- After a jump at posedge n, the first request to jump_target is driven in cycle n+1. The new ir_valid appears no earlier than posedge n+WORDS.
- mem_read_en is never asserted in HOLD unless prefetch is compiled in.

## Configuration
- Macro: FETCH_UNIT_PREFETCH_EN.
- Defined: adds a one-entry prefetch buffer (instruction + pc).
  - FETCH continues while ir_valid=1.
  - A completed instruction goes to ir if ir is empty or transferring that cycle, else into the buffer.
  - FETCH stalls (mem_read_en=0) only when ir and the buffer are both full.
  - On a transfer with the buffer full, the buffer moves into ir on the same posedge and fetch resumes next cycle.
  - Ordering is strictly preserved.
  - With ir_ready held 1 and single-cycle ack, throughput is one instruction per WORDS cycles.
  - Jump empties the buffer.
- Undefined: no buffer; behaviour exactly as in Operation.

## Test plan
Setup for all scenarios: MEM_DATA_BITS=8, INSTR_BITS=16, memory bytes 0x12,0x34,0x56,0x78 at addresses 0..3, single-cycle ack, unless stated otherwise.
- Reset, then ir_ready=1 → ir=0x1234/pc=0 then ir=0x5678/pc=2. Spacing is 3 cycles without prefetch and 2 with prefetch. Reset values of all outputs are checked.
- ir_ready=0 for 10 cycles after the first instruction → ir holds 0x1234 stable.
  - Without prefetch, mem_read_en=0 throughout.
  - With prefetch, exactly one more instruction (0x5678) is fetched, then mem_read_en=0.
- mem_ack delayed 3 cycles per word → ir=0x1234 arrives 8 cycles after reset release, with mem_address held at 0 and then 1 while waiting.
- jump_en with target 0x02, asserted mid-fetch after the first byte is acked → the partial 0x12 is discarded, the next ir=0x5678 with pc=2, and the simultaneous ack is ignored.
- Memory at addresses 0xFF=0xAB and 0x00=0xCD, jump to 0xFF → ir=0xABCD, ir_pc=0xFF, next fetch address 0x01.
- Reset asserted while ir_valid=1 and a request is outstanding → next cycle all outputs are 0, then fetching restarts at address 0.
